mem_access_stage: RTL and testbench

- Memory stage between the execute stage and writeback.
- Registers the execute result and destination register.
- For loads and stores, runs a req/ack transaction with data memory, stalls upstream while it waits, and aligns, sign/zero-extends and byte-enables the data.
- Flags misaligned accesses and memory timeouts instead of hanging the pipeline.

---
 rtl/mem_access_stage_if.sv | 41 ++++
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Signal bundle between the memory stage, the execute stage, data memory and writeback.
// The slave view belongs to the stage; the master view belongs to its environment.
interface mem_access_stage_if;
  logic        in_valid;
  logic        in_is_load;
  logic        in_is_store;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_func3;
  logic [4:0]  in_rd;
  logic        stall;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_addr, in_wdata, in_func3, in_rd,
    input  dmem_ack, dmem_rdata,
    output stall,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output out_valid, out_data, out_rd, out_err
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_addr, in_wdata, in_func3, in_rd,
    output dmem_ack, dmem_rdata,
    input  stall,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  out_valid, out_data, out_rd, out_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: forwards ALU results, runs one req/ack data-memory
// transaction per aligned load/store, and reports misaligned or timed-out accesses.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  mem_access_stage_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             ld_q, ld_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic [4:0]       rd_q, rd_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_err_q, out_err_d;

  logic             is_mem;
  logic             misaligned;
  logic             stall_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      rshift;
  logic [31:0]      load_data;

  assign is_mem = bus.in_is_load | bus.in_is_store;

  // Size code 11 is not a legal RISC-V width; it is handled like a word.
  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'hF;
    wdata_c    = bus.in_wdata;
    case (bus.in_func3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << bus.in_addr[1:0];
        wdata_c = {4{bus.in_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = bus.in_addr[0];
        be_c       = 4'b0011 << bus.in_addr[1:0];
        wdata_c    = {2{bus.in_wdata[15:0]}};
      end
      default: misaligned = |bus.in_addr[1:0];
    endcase
  end

  // Read word is shifted so the addressed lane lands in bits [7:0] / [15:0].
  assign rshift = bus.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rshift;
    case (f3_q[1:0])
      2'b00:   load_data = {{24{~f3_q[2] & rshift[7]}},  rshift[7:0]};
      2'b01:   load_data = {{16{~f3_q[2] & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  // NOTE: every _d takes its _q value first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ld_d        = ld_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_err_d   = out_err_q;
    stall_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_addr;
            out_rd_d    = bus.in_rd;
            out_err_d   = 1'b0;
          end else if (misaligned) begin
            out_valid_d = 1'b1;
            out_data_d  = 32'h0;
            out_rd_d    = bus.in_rd;
            out_err_d   = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ~bus.in_is_load;
            addr_d  = {bus.in_addr[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
            ld_d    = bus.in_is_load;
            off_d   = bus.in_addr[1:0];
            f3_d    = bus.in_func3;
            rd_d    = bus.in_rd;
          end
        end
      end

      WAIT: begin
        if (bus.dmem_ack) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = ld_q ? load_data : 32'h0;
          out_rd_d    = rd_q;
          out_err_d   = 1'b0;
        end else begin
          stall_c = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d     = IDLE;
            req_d       = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = 32'h0;
            out_rd_d    = rd_q;
            out_err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      ld_q        <= 1'b0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      rd_q        <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_rd_q    <= 5'd0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ld_q        <= ld_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases with literal expectations,
// then randomized instructions and memory latencies checked against a transaction model.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expectations for the current cycle, and the result due after the next edge.
  logic        chk_en = 1'b0;
  logic        stall_dc = 1'b0;
  logic        exp_zero = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_ov = 1'b0;
  logic [31:0] exp_od = '0;
  logic [4:0]  exp_ord = '0;
  logic        exp_oerr = 1'b0;
  logic        nxt_ov = 1'b0;
  logic [31:0] nxt_od = '0;
  logic [4:0]  nxt_ord = '0;
  logic        nxt_oerr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (spec-level arithmetic) ----------------
  function automatic logic is_misaligned(input logic [31:0] a, input logic [2:0] f3);
    int sz = int'(f3[1:0]);
    return (sz == 1 && a % 2 != 0) || (sz >= 2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
    int lane = int'(a % 4);
    case (f3[1:0])
      2'b00:   return 4'(1 << lane);
      2'b01:   return 4'(3 << lane);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return (w & 32'hFF) * 32'h0101_0101;
      2'b01:   return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = rdata >> (8 * int'(a % 4));
    case (f3[1:0])
      2'b00:   return f3[2] ? (s & 32'hFF)   : 32'($signed(s[7:0]));
      2'b01:   return f3[2] ? (s & 32'hFFFF) : 32'($signed(s[15:0]));
      default: return s;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (!stall_dc) check("stall", bus.stall, exp_stall);
      check("dmem_req", bus.dmem_req, exp_req);
      if (exp_req) begin
        check("dmem_we", bus.dmem_we, exp_we);
        check("dmem_addr", bus.dmem_addr, exp_addr);
        check("dmem_be", bus.dmem_be, exp_be);
        if (exp_we) check("dmem_wdata", bus.dmem_wdata, exp_wdata);
      end
      check("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
        check("out_err", bus.out_err, exp_oerr);
        check("out_data", bus.out_data, exp_od);
        if (!exp_oerr) check("out_rd", bus.out_rd, exp_ord);
      end
      if (exp_zero) begin
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_rd", bus.out_rd, 32'h0);
        check("rst_out_err", bus.out_err, 32'h0);
        check("rst_dmem_we", bus.dmem_we, 32'h0);
        check("rst_dmem_be", bus.dmem_be, 32'h0);
        check("rst_dmem_addr", bus.dmem_addr, 32'h0);
        check("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    exp_ov   = nxt_ov;
    exp_od   = nxt_od;
    exp_ord  = nxt_ord;
    exp_oerr = nxt_oerr;
    nxt_ov   = 1'b0;
    exp_req  = 1'b0;
    exp_stall = 1'b0;
    stall_dc = 1'b0;
    exp_zero = 1'b0;
    chk_en   = 1'b1;
    bus.in_valid = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic set_nxt(input logic [31:0] d, input logic [4:0] rd, input logic err);
    nxt_ov = 1'b1; nxt_od = d; nxt_ord = rd; nxt_oerr = err;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic late_ack();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = $urandom;
    step();
  endtask

  // ack_dly: index of the WAIT cycle carrying the ack; >= TO means no ack (timeout).
  task automatic run_op(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] w,
                        input logic [2:0] f3, input logic [4:0] rd, input int ack_dly,
                        input logic [31:0] rdata, input logic [31:0] e_data,
                        input logic [3:0] e_be, input logic [31:0] e_wdata);
    bus.in_valid = 1'b1; bus.in_is_load = ld; bus.in_is_store = st;
    bus.in_addr = a; bus.in_wdata = w; bus.in_func3 = f3; bus.in_rd = rd;
    if (!(ld || st)) begin
      set_nxt(a, rd, 1'b0);
      step();
    end else if (is_misaligned(a, f3)) begin
      set_nxt(32'h0, rd, 1'b1);
      step();
    end else begin
      exp_stall = 1'b1;
      step();
      for (int k = 0; k < TO; k++) begin
        exp_req = 1'b1; exp_we = st && !ld; exp_addr = a & 32'hFFFF_FFFC;
        exp_be = e_be; exp_wdata = e_wdata;
        // The held instruction's fields are scrambled to prove the stage uses latched copies.
        bus.in_valid = 1'b1; bus.in_addr = $urandom; bus.in_wdata = $urandom;
        bus.in_func3 = 3'($urandom); bus.in_rd = 5'($urandom);
        if (k == ack_dly) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
          set_nxt(e_data, rd, 1'b0);
          step();
          break;
        end
        bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
        exp_stall = 1'b1;
        if (k == TO - 1) set_nxt(32'h0, rd, 1'b1);
        step();
      end
    end
  endtask

  initial begin
    logic        ld, st;
    logic [31:0] a, w, rdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          kind, dly;

    bus.in_valid = 0; bus.in_is_load = 0; bus.in_is_store = 0; bus.in_addr = '0;
    bus.in_wdata = '0; bus.in_func3 = '0; bus.in_rd = '0; bus.dmem_ack = 0; bus.dmem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1; exp_zero = 1'b1; exp_ov = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
    rst_n = 1'b1;
    step();

    // Directed cases with hand-computed expectations.
    run_op(0, 0, 32'h1234_5678, 32'h0, 3'b000, 5'd5, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    run_op(1, 0, 32'h0000_0103, 32'h0, 3'b000, 5'd7, 2, 32'h80FF_0000,
           32'hFFFF_FF80, 4'b1000, 32'h0);
    run_op(1, 0, 32'h0000_0202, 32'h0, 3'b101, 5'd9, 0, 32'hBEEF_0000,
           32'h0000_BEEF, 4'b1100, 32'h0);
    run_op(0, 1, 32'h0000_0012, 32'hAAAA_1234, 3'b001, 5'd3, 1, 32'h0,
           32'h0, 4'b1100, 32'h1234_1234);
    run_op(1, 0, 32'h0000_0002, 32'h0, 3'b010, 5'd4, 0, 32'h0, 32'h0, 4'hF, 32'h0);
    run_op(1, 0, 32'h0000_0040, 32'h0, 3'b010, 5'd6, TO, 32'h0, 32'h0, 4'hF, 32'h0);
    late_ack();
    idle(1);
    run_op(1, 1, 32'h0000_0081, 32'h0, 3'b100, 5'd8, 3, 32'h1234_5678,
           32'h0000_0056, 4'b0010, 32'h0);

    // Reset in the middle of a WAIT: request drops, no result, later ack ignored.
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
    bus.in_addr = 32'h80; bus.in_func3 = 3'b010; bus.in_rd = 5'd2;
    exp_stall = 1'b1;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h80; exp_be = 4'hF;
    bus.in_valid = 1'b1; exp_stall = 1'b1;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h80; exp_be = 4'hF;
    rst_n = 1'b0; stall_dc = 1'b1;
    step();
    rst_n = 1'b1; exp_zero = 1'b1;
    late_ack();
    idle(2);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      ld = (kind == 1 || kind == 3);
      st = (kind == 2 || kind == 3);
      f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      w = $urandom; rdata = $urandom; rd = 5'($urandom);
      dly = $urandom_range(0, TO);
      run_op(ld, st, a, w, f3, rd, dly, rdata, ld ? m_load(rdata, a, f3) : 32'h0,
             m_be(a, f3), m_wdata(w, f3));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) late_ack();
        else idle(1);
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
